// File: rtl/ram_sort_ctrl.sv
// In-place bubble-sort sequencer driving a single-port RAM with one-cycle read latency.
// Define SORT_DESC_EN for a descending sort; the default build sorts ascending.
module ram_sort_ctrl #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2*ADDR_W-1:0]   swap_count,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] CMP  = 3'd3;
    localparam logic [2:0] WR_A = 3'd4;
    localparam logic [2:0] WR_B = 3'd5;
    localparam logic [2:0] ADV  = 3'd6;
    localparam logic [2:0] DONE = 3'd7;

    localparam int unsigned N          = 2 ** ADDR_W;
    localparam int unsigned CNT_W      = 2 * ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_BOUND = ADDR_W'(N - 2);

    logic [2:0]        state;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] bound;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              swapped;
    logic              do_swap;

    // In CMP, ram_dout already carries mem[i+1].
`ifdef SORT_DESC_EN
    assign do_swap = a < ram_dout;
`else
    assign do_swap = a > ram_dout;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            bound      <= '0;
            a          <= '0;
            b          <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i          <= '0;
                        bound      <= LAST_BOUND;
                        swapped    <= 1'b0;
                        swap_count <= '0;
                        state      <= RD_A;
                    end
                end
                RD_A: state <= RD_B;
                RD_B: begin
                    a     <= ram_dout;
                    state <= CMP;
                end
                CMP: begin
                    b     <= ram_dout;
                    state <= do_swap ? WR_A : ADV;
                end
                WR_A: state <= WR_B;
                WR_B: begin
                    swapped    <= 1'b1;
                    swap_count <= swap_count + CNT_W'(1);
                    state      <= ADV;
                end
                ADV: begin
                    if (i != bound) begin
                        i     <= i + ADDR_W'(1);
                        state <= RD_A;
                    end else if (bound == '0 || !swapped) begin
                        state <= DONE;
                    end else begin
                        bound   <= bound - ADDR_W'(1);
                        i       <= '0;
                        swapped <= 1'b0;
                        state   <= RD_A;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port is decoded from state and registers only, never from ram_dout.
    always_comb begin
        busy     = (state != IDLE) && (state != DONE);
        done     = (state == DONE);
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            RD_A: ram_addr = i;
            RD_B: ram_addr = i + ADDR_W'(1);
            WR_A: begin
                ram_we   = 1'b1;
                ram_addr = i;
                ram_din  = b;
            end
            WR_B: begin
                ram_we   = 1'b1;
                ram_addr = i + ADDR_W'(1);
                ram_din  = a;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_sort_ctrl.sv
// Bench for ram_sort_ctrl: table vectors, hand-written corner sequences and random arrays
// checked against an array-level bubble-sort model.
module tb_ram_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, ram_we;
    logic [3:0] swap_count;
    logic [1:0] ram_addr;
    logic [7:0] ram_din, ram_dout;

    // Behavioural single-port RAM, shared reset, plus a preload port for the bench.
    logic [7:0] mem [0:3];
    logic [1:0] rd_addr;
    logic       pl_we = 1'b0;
    logic [1:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) mem[j] <= '0;
            rd_addr <= '0;
        end else begin
            if (pl_we) mem[pl_addr] <= pl_data;
            else if (ram_we) mem[ram_addr] <= ram_din;
            rd_addr <= ram_addr;
        end
    end
    assign ram_dout = mem[rd_addr];

    ram_sort_ctrl #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .swap_count(swap_count), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    typedef struct {
        logic [3:0][7:0] init;
        logic [3:0][7:0] exp;
        int              swaps;
        int              cycles;
    } vec_t;

    vec_t            vecs [4];
    int              checks = 0;
    int              failures = 0;
    logic [3:0][7:0] pre;
    int              r_busy, r_done_at, r_writes, r_noop, r_after_done;

    function automatic logic [3:0][7:0] p4(input logic [7:0] m0, m1, m2, m3);
        return {m3, m2, m1, m0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Array-level reference: passes over a shrinking prefix, stop after a clean pass.
    task automatic model(input logic [3:0][7:0] in, output logic [3:0][7:0] out,
                         output int sw, output int cy);
        logic [7:0] t;
        int         comps;
        bit         any;
        out = in; sw = 0; comps = 0;
        for (int bnd = 2; bnd >= 0; bnd--) begin
            any = 0;
            for (int j = 0; j <= bnd; j++) begin
                comps++;
`ifdef SORT_DESC_EN
                if (out[j] < out[j+1]) begin
`else
                if (out[j] > out[j+1]) begin
`endif
                    t = out[j]; out[j] = out[j+1]; out[j+1] = t;
                    sw++; any = 1;
                end
            end
            if (!any) break;
        end
        cy = 4 * comps + 2 * sw;
    endtask

    task automatic preload();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = 2'(j); pl_data = pre[j];
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Pulses start, then samples each cycle k+n on the falling edge until done.
    task automatic do_sort(input bit poke);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; r_busy = 0; r_done_at = 0; r_writes = 0; r_noop = 0;
        while (n < 400 && r_done_at == 0) begin
            if (busy) r_busy++;
            if (ram_we) begin
                r_writes++;
                if (ram_din == mem[ram_addr]) r_noop++;
            end
            if (done) r_done_at = n;
            else begin
                start = poke && (n == 5 || n == 9);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        @(negedge clk);
        r_after_done = {30'd0, done, busy};
    endtask

    task automatic run_check(input string tag, input logic [3:0][7:0] exp,
                             input int sw, input int cy, input bit poke);
        preload();
        do_sort(poke);
        chk({tag, " done_seen"}, int'(r_done_at != 0), 1);
        chk({tag, " done_cycle"}, r_done_at, cy + 1);
        chk({tag, " busy_cycles"}, r_busy, cy);
        chk({tag, " swap_count"}, int'(swap_count), sw);
        chk({tag, " writes"}, r_writes, 2 * sw);
        chk({tag, " noop_writes"}, r_noop, 0);
        chk({tag, " done_pulse"}, r_after_done, 0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s mem%0d", tag, j), int'(mem[j]), int'(exp[j]));
    endtask

    initial begin
        logic [3:0][7:0] e;
        int              sw, cy, n;

`ifdef SORT_DESC_EN
        vecs[0] = '{p4(1, 2, 3, 4), p4(4, 3, 2, 1), 6, 36};
        vecs[1] = '{p4(4, 3, 2, 1), p4(4, 3, 2, 1), 0, 12};
        vecs[2] = '{p4(3, 3, 1, 3), p4(3, 3, 3, 1), 1, 22};
        vecs[3] = '{p4(2, 1, 3, 4), p4(4, 3, 2, 1), 5, 34};
`else
        vecs[0] = '{p4(1, 2, 3, 4), p4(1, 2, 3, 4), 0, 12};
        vecs[1] = '{p4(4, 3, 2, 1), p4(1, 2, 3, 4), 6, 36};
        vecs[2] = '{p4(3, 3, 1, 3), p4(1, 3, 3, 3), 2, 28};
        vecs[3] = '{p4(2, 1, 3, 4), p4(1, 2, 3, 4), 1, 22};
`endif

        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset ram_we", int'(ram_we), 0);
        chk("reset ram_addr", int'(ram_addr), 0);
        chk("reset ram_din", int'(ram_din), 0);
        chk("reset swap_count", int'(swap_count), 0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            pre = vecs[v].init;
            run_check($sformatf("vec%0d", v), vecs[v].exp, vecs[v].swaps, vecs[v].cycles, 1'b0);
        end

        // start re-asserted while busy must not perturb result or timing
        pre = vecs[1].init;
        run_check("poke", vecs[1].exp, vecs[1].swaps, vecs[1].cycles, 1'b1);

        // reset during the first WR_A cycle
        pre = p4(4, 3, 2, 1);
        preload();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!ram_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst wr_a_reached", int'(ram_we), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst ram_we", int'(ram_we), 0);
        chk("rst swap_count", int'(swap_count), 0);
        for (int j = 0; j < 4; j++) chk($sformatf("rst mem%0d", j), int'(mem[j]), 0);
        rst = 1'b0;
        pre = vecs[1].init;
        run_check("after_rst", vecs[1].exp, vecs[1].swaps, vecs[1].cycles, 1'b0);

        // start held high: a new sort begins on the first IDLE cycle after DONE
        pre = vecs[0].init;
        preload();
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold done_cycle", n, vecs[0].cycles + 1);
        @(negedge clk);
        chk("hold idle_busy", int'(busy), 0);
        @(negedge clk);
        chk("hold restart_busy", int'(busy), 1);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold second_done", int'(done), 1);
        @(negedge clk);

        // random arrays with a narrow value range to force duplicates
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 4; j++) pre[j] = 8'($urandom_range(0, 7));
            model(pre, e, sw, cy);
            run_check($sformatf("rand%0d", r), e, sw, cy, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_sort_ctrl.md
# ram_sort_ctrl

In-place bubble-sort sequencer for the single-port sorting RAM (2**ADDR_W words, registered read address, one-cycle read latency). On `start` it drives the RAM's `we/addr/din` port and consumes `dout`, comparing adjacent pairs and swapping them until the array is ordered. It then pulses `done`. It is the sole master of the RAM port while `busy` is high and sits between the top-level control FSM and the RAM instance.

## Interface
- ADDR_W, 2, RAM address width (N = 2**ADDR_W entries, ADDR_W >= 1)
- DATA_W, 8, RAM data width; values compared as unsigned
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin sort; sampled only in IDLE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse (DONE state)
- swap_count  out  2*ADDR_W  swaps performed by the last/current sort
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data (= mem[address presented previous cycle])

## Operation
- Registers:
  - `i` (ADDR_W), compare index
  - `bound` (ADDR_W), last index of the pass
  - `a`, `b` (DATA_W)
  - `swapped` (1)
  - `swap_count`
- States and transitions:
  - IDLE: `ram_we`=0, `ram_addr`=0, `ram_din`=0. If `start`: `i`<=0, `bound`<=N-2, `swapped`<=0, `swap_count`<=0, go to RD_A.
  - RD_A: `ram_addr`=`i`. Go to RD_B.
  - RD_B: `ram_addr`=`i`+1. `a`<=`ram_dout` (mem[i]). Go to CMP.
  - CMP: `b`<=`ram_dout` (mem[i+1]). If `a` > `ram_dout`, go to WR_A; otherwise go to ADV.
  - WR_A: `ram_we`=1, `ram_addr`=`i`, `ram_din`=`b`. Go to WR_B.
  - WR_B: `ram_we`=1, `ram_addr`=`i`+1, `ram_din`=`a`. `swapped`<=1, `swap_count`++. Go to ADV.
  - ADV, when `i`!=`bound`: `i`++, go to RD_A.
  - ADV, when `i`==`bound`: if `bound`==0 or `swapped`==0, go to DONE. Otherwise `bound`--, `i`<=0, `swapped`<=0, go to RD_A.
  - DONE: `done`=1, go to IDLE.
- Equal values are never swapped, so the sort is stable. No write is ever issued for an already-ordered pair.
- `start` outside IDLE is ignored. `start` held high re-triggers a new sort on the first IDLE cycle after DONE.
- `swap_count` holds its value after DONE until the next accepted `start`. It cannot overflow, since the maximum N(N-1)/2 is less than 2**(2*ADDR_W).
- ADDR_W=1: `bound`=0, so exactly one comparison is made.

## Timing
- Reset values: `busy` 0, `done` 0, `ram_we` 0, `ram_addr` 0, `ram_din` 0, `swap_count` 0, state IDLE.
- All RAM-port outputs are decoded from state and registers only; there is no combinational path from `ram_dout`.
- `start` is sampled at edge k. `busy` is high from cycle k+1.
- Per comparison: 4 cycles without a swap, 6 cycles with a swap.
- Completion: `done` is asserted in the cycle after the final ADV, with `busy` low in that cycle.
- Already-sorted N=4: 3 comparisons, 12 busy cycles, `done` in cycle k+13.
- Reverse-sorted N=4: 6 swapping comparisons, 36 busy cycles.
- Reset mid-operation: state returns to IDLE at the reset edge and `ram_we` is 0 from the next cycle.
  - The RAM may be left partially sorted.
  - After WR_A without WR_B, one value is duplicated. The system asserts RAM `rst` together with this block's `rst`.

## Configuration
- `SORT_DESC_EN` defined: the CMP swap condition becomes `a` < `ram_dout`, giving a descending sort. Everything else is unchanged.
- `SORT_DESC_EN` undefined: the swap condition is `a` > `ram_dout`, giving an ascending sort.

## Test plan
- Preload RAM [1,2,3,4], pulse `start` -> no `ram_we` ever high, `done` at k+13, `swap_count`=0, RAM [1,2,3,4].
- Preload [4,3,2,1] -> 36 busy cycles, `swap_count`=6, RAM [1,2,3,4], `done` a single-cycle pulse.
- Preload [3,3,1,3] -> RAM [1,3,3,3], `swap_count`=2, no write to a pair of equal values.
- Preload [4,3,2,1], assert `start` again during `busy` -> ignored; result and timing identical to the unperturbed run.
- Preload [4,3,2,1], assert `rst` (this block and RAM) during a WR_A cycle -> next cycle `busy`=0, `ram_we`=0, `swap_count`=0, RAM all 0. A fresh `start` sorts correctly.
- With `SORT_DESC_EN`, preload [1,2,3,4] -> RAM [4,3,2,1], `swap_count`=6.
